// File: rtl/reconciled_key_frame_reader_pkg.sv
// Shared definitions for the reconciled-key frame reader: FSM encoding, widths,
// header sync byte and header-word helper.
`ifndef FRAME_ROUND_WIDTH
`define FRAME_ROUND_WIDTH 8
`endif

package reconciled_key_frame_reader_pkg;

  localparam int RKFR_ADDR_WIDTH   = 15;
  localparam int RKFR_DATA_WIDTH   = 64;
  localparam int RKFR_OFFSET_WIDTH = 15;
  localparam logic [7:0] RKFR_SYNC_BYTE = 8'hA5;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_HDR  = 3'd1,
    S_RD   = 3'd2,
    S_LAT  = 3'd3,
    S_HI   = 3'd4,
    S_LO   = 3'd5,
    S_DONE = 3'd6,
    S_DROP = 3'd7
  } rkfr_state_e;

  function automatic logic [31:0] rkfr_header_word(input logic [7:0]  round8,
                                                   input logic [15:0] len);
    return {RKFR_SYNC_BYTE, round8, len};
  endfunction

endpackage

// File: rtl/reconciled_key_frame_reader.sv
// Reads one frame of 64-bit reconciled key from BRAM port B and streams it as
// 32-bit words (high half first) into the PA input FIFO. Optional header word: RKFR_HEADER_EN.
`ifndef FRAME_ROUND_WIDTH
`define FRAME_ROUND_WIDTH 8
`endif

module reconciled_key_frame_reader
  import reconciled_key_frame_reader_pkg::*;
#(
  parameter int FRAME_WORDS = 16384,
  parameter int HALF_BASE   = 16384
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start_read,
  input  logic                          ev_fail,
  input  logic                          addr_index,
  input  logic [`FRAME_ROUND_WIDTH-1:0] frame_round,
  output logic                          rk_clkb,
  output logic                          rk_enb,
  output logic                          rk_web,
  output logic [RKFR_ADDR_WIDTH-1:0]    rk_addrb,
  input  logic [RKFR_DATA_WIDTH-1:0]    rk_doutb,
  output logic                          pa_wr_clk,
  output logic                          pa_wr_en,
  output logic [31:0]                   pa_wr_din,
  input  logic                          pa_full,
  output logic                          busy,
  output logic                          frame_done,
  output logic                          frame_dropped,
  output rkfr_state_e                   dbg_state
);

  localparam logic [RKFR_OFFSET_WIDTH-1:0] LAST_OFFSET = RKFR_OFFSET_WIDTH'(FRAME_WORDS - 1);
  localparam logic [RKFR_ADDR_WIDTH-1:0]   HALF_BASE_A = RKFR_ADDR_WIDTH'(HALF_BASE);

`ifdef RKFR_HEADER_EN
  localparam rkfr_state_e FIRST_STATE = S_HDR;
  localparam logic [15:0] HDR_LEN     = 16'(2 * FRAME_WORDS);
  logic [`FRAME_ROUND_WIDTH-1:0] round_q;
`else
  localparam rkfr_state_e FIRST_STATE = S_RD;
  logic unused_round;
  assign unused_round = ^frame_round;
`endif

  rkfr_state_e                  state, state_nx;
  logic [RKFR_ADDR_WIDTH-1:0]   base_q;
  logic [RKFR_OFFSET_WIDTH-1:0] offset_q;
  logic [RKFR_DATA_WIDTH-1:0]   word_q;
  logic                         accept;

  // Requests arriving outside IDLE (including the DONE cycle) are ignored.
  assign accept = (state == S_IDLE) && start_read;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base_q   <= '0;
      offset_q <= '0;
      word_q   <= '0;
    end else begin
      if (accept) begin
        base_q   <= addr_index ? HALF_BASE_A : '0;
        offset_q <= '0;
      end
      if (state == S_LAT) word_q <= rk_doutb;
      if ((state == S_LO) && !pa_full && (offset_q != LAST_OFFSET))
        offset_q <= offset_q + 1'b1;
    end
  end

`ifdef RKFR_HEADER_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      round_q <= '0;
    else if (accept) round_q <= frame_round;
  end
`endif

  always_comb begin
    state_nx  = state;
    rk_enb    = 1'b0;
    pa_wr_en  = 1'b0;
    pa_wr_din = '0;
    unique case (state)
      S_IDLE: if (start_read) state_nx = ev_fail ? S_DROP : FIRST_STATE;
`ifdef RKFR_HEADER_EN
      S_HDR: begin
        pa_wr_din = rkfr_header_word(8'(round_q), HDR_LEN);
        pa_wr_en  = !pa_full;
        if (!pa_full) state_nx = S_RD;
      end
`endif
      S_RD: begin
        rk_enb   = 1'b1;
        state_nx = S_LAT;
      end
      S_LAT: state_nx = S_HI;
      S_HI: begin
        pa_wr_din = word_q[63:32];
        pa_wr_en  = !pa_full;
        if (!pa_full) state_nx = S_LO;
      end
      S_LO: begin
        pa_wr_din = word_q[31:0];
        pa_wr_en  = !pa_full;
        if (!pa_full) state_nx = (offset_q == LAST_OFFSET) ? S_DONE : S_RD;
      end
      S_DONE:  state_nx = S_IDLE;
      S_DROP:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  assign rk_clkb       = clk;
  assign pa_wr_clk     = clk;
  assign rk_web        = 1'b0;
  assign rk_addrb      = base_q + offset_q;
  assign busy          = (state != S_IDLE);
  assign frame_done    = (state == S_DONE);
  assign frame_dropped = (state == S_DROP);
  assign dbg_state     = state;

endmodule

// File: tb/tb_reconciled_key_frame_reader.sv
// Randomized bench for reconciled_key_frame_reader: BRAM model, expected FIFO and
// address queues built from the frame rules, cycle-relative timing checks.
`ifndef FRAME_ROUND_WIDTH
`define FRAME_ROUND_WIDTH 8
`endif

module tb_reconciled_key_frame_reader;
  import reconciled_key_frame_reader_pkg::*;

  localparam int FW = 4;
  localparam int HB = 16384;
`ifdef RKFR_HEADER_EN
  localparam int HDR_N = 1;
`else
  localparam int HDR_N = 0;
`endif

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic                          start_read = 1'b0;
  logic                          ev_fail = 1'b0;
  logic                          addr_index = 1'b0;
  logic [`FRAME_ROUND_WIDTH-1:0] frame_round = '0;
  logic                          rk_clkb, rk_enb, rk_web;
  logic [14:0]                   rk_addrb;
  logic [63:0]                   rk_doutb = '0;
  logic                          pa_wr_clk, pa_wr_en;
  logic [31:0]                   pa_wr_din;
  logic                          pa_full = 1'b0;
  logic                          busy, frame_done, frame_dropped;
  rkfr_state_e                   dbg_state;

  reconciled_key_frame_reader #(.FRAME_WORDS(FW), .HALF_BASE(HB)) dut (
    .clk(clk), .rst_n(rst_n), .start_read(start_read), .ev_fail(ev_fail),
    .addr_index(addr_index), .frame_round(frame_round),
    .rk_clkb(rk_clkb), .rk_enb(rk_enb), .rk_web(rk_web), .rk_addrb(rk_addrb),
    .rk_doutb(rk_doutb), .pa_wr_clk(pa_wr_clk), .pa_wr_en(pa_wr_en),
    .pa_wr_din(pa_wr_din), .pa_full(pa_full), .busy(busy),
    .frame_done(frame_done), .frame_dropped(frame_dropped), .dbg_state(dbg_state)
  );

  // BRAM model: registered read
  logic [63:0] mem [0:32767];
  always @(posedge clk) if (rk_enb) rk_doutb <= mem[rk_addrb];

  // scoreboard
  logic [31:0] exp_q[$];
  logic [14:0] addr_q[$];
  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int start_cyc = 0;
  int done_cnt, drop_cnt, wr_cnt, rd_cnt;
  int done_rel, drop_rel, first_rd_rel, first_wr_rel, busy_rise_rel, busy_fall_rel;
  logic prev_busy = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // monitor, sampled away from the active edge
  always @(negedge clk) begin
    if (rst_n) begin
      if (pa_wr_en) begin
        check("wr_while_full", pa_full, 1'b0);
        check("fifo_extra_wr", exp_q.size() > 0, 1'b1);
        if (exp_q.size() > 0) check("fifo_data", pa_wr_din, exp_q.pop_front());
        if (wr_cnt == 0) first_wr_rel = cyc - start_cyc;
        wr_cnt++;
      end
      if (rk_enb) begin
        check("bram_extra_rd", addr_q.size() > 0, 1'b1);
        if (addr_q.size() > 0) check("bram_addr", rk_addrb, addr_q.pop_front());
        if (rd_cnt == 0) first_rd_rel = cyc - start_cyc;
        rd_cnt++;
      end
      if (frame_done) begin done_cnt++; done_rel = cyc - start_cyc; end
      if (frame_dropped) begin drop_cnt++; drop_rel = cyc - start_cyc; end
      if (busy && !prev_busy) busy_rise_rel = cyc - start_cyc;
      if (!busy && prev_busy) busy_fall_rel = cyc - start_cyc;
    end
    prev_busy = busy;
  end

  // driver: fill BRAM, queue expectations, pulse start_read
  task automatic launch(input bit fail, input bit idx, input logic [`FRAME_ROUND_WIDTH-1:0] rnd,
                        input bit first_pat);
    int base;
    logic [7:0] r8;
    base = idx ? HB : 0;
    r8 = 8'(rnd);
    done_cnt = 0; drop_cnt = 0; wr_cnt = 0; rd_cnt = 0;
    done_rel = -1; drop_rel = -1; first_rd_rel = -1; first_wr_rel = -1;
    busy_rise_rel = -1; busy_fall_rel = -1;
    if (!fail) begin
      if (HDR_N == 1) exp_q.push_back({8'hA5, r8, 16'(2 * FW)});
      for (int i = 0; i < FW; i++) begin
        mem[base + i] = first_pat ? {32'hAAAA_0001 + 32'(i), 32'hBBBB_0001 + 32'(i)}
                                  : {$urandom, $urandom};
        addr_q.push_back(15'(base + i));
        exp_q.push_back(mem[base + i][63:32]);
        exp_q.push_back(mem[base + i][31:0]);
      end
    end
    @(posedge clk); #1;
    start_read  = 1'b1;
    ev_fail     = fail;
    addr_index  = idx;
    frame_round = rnd;
    start_cyc   = cyc;
  endtask

  task automatic finish_frame(input bit fail, input bit rand_full, input bit extra);
    for (int c = 0; c < 400; c++) begin
      @(posedge clk); #1;
      if (done_cnt + drop_cnt > 0) break;
      pa_full = rand_full ? 1'($urandom_range(0, 1)) : 1'b0;
      if (extra) begin
        start_read = ($urandom_range(0, 2) == 0);
        ev_fail    = 1'($urandom_range(0, 1));
        addr_index = 1'($urandom_range(0, 1));
      end else begin
        start_read = 1'b0;
      end
    end
    start_read = 1'b0;
    pa_full    = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("done_count", done_cnt, fail ? 0 : 1);
    check("drop_count", drop_cnt, fail ? 1 : 0);
    check("bram_reads", rd_cnt, fail ? 0 : FW);
    check("fifo_writes", wr_cnt, fail ? 0 : 2 * FW + HDR_N);
    check("exp_q_left", exp_q.size(), 0);
    check("busy_idle", busy, 1'b0);
    check("busy_rise", busy_rise_rel, 1);
    if (fail) begin
      check("drop_cycle", drop_rel, 1);
      check("drop_busy_fall", busy_fall_rel, 2);
    end else if (!rand_full) begin
      check("first_rd_cycle", first_rd_rel, 1 + HDR_N);
      check("first_wr_cycle", first_wr_rel, HDR_N ? 1 : 3);
      check("done_cycle", done_rel, 4 * FW + 1 + HDR_N);
      check("busy_fall", busy_fall_rel, 4 * FW + 2 + HDR_N);
    end
    exp_q.delete();
    addr_q.delete();
  endtask

  initial begin
    #1;
    check("rst_rk_enb", rk_enb, 1'b0);
    check("rst_rk_addrb", rk_addrb, 15'd0);
    check("rst_rk_web", rk_web, 1'b0);
    check("rst_pa_wr_en", pa_wr_en, 1'b0);
    check("rst_pa_wr_din", pa_wr_din, 32'd0);
    check("rst_busy", busy, 1'b0);
    check("rst_frame_done", frame_done, 1'b0);
    check("rst_frame_dropped", frame_dropped, 1'b0);
    check("rst_state", dbg_state, S_IDLE);
    check("rk_clkb_follows_clk", rk_clkb, clk);
    check("pa_wr_clk_follows_clk", pa_wr_clk, clk);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // directed frame: upper half, round 5, counting pattern
    launch(1'b0, 1'b1, `FRAME_ROUND_WIDTH'(5), 1'b1);
    finish_frame(1'b0, 1'b0, 1'b0);

    // dropped frame
    launch(1'b1, 1'b0, `FRAME_ROUND_WIDTH'(9), 1'b0);
    finish_frame(1'b1, 1'b0, 1'b0);

    // random backpressure
    for (int f = 0; f < 4; f++) begin
      launch(1'b0, 1'($urandom_range(0, 1)), `FRAME_ROUND_WIDTH'($urandom), 1'b0);
      finish_frame(1'b0, 1'b1, 1'b0);
    end

    // abort mid-frame with reset after three writes
    launch(1'b0, 1'b0, `FRAME_ROUND_WIDTH'(3), 1'b0);
    for (int c = 0; c < 200; c++) begin
      @(posedge clk); #1;
      start_read = 1'b0;
      if (wr_cnt >= 3) break;
    end
    rst_n = 1'b0;
    #1;
    check("abort_busy", busy, 1'b0);
    check("abort_state", dbg_state, S_IDLE);
    check("abort_wr_en", pa_wr_en, 1'b0);
    exp_q.delete();
    addr_q.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    check("abort_no_done", done_cnt, 0);
    check("abort_wr_count", wr_cnt, 3);
    check("abort_busy_after", busy, 1'b0);
    launch(1'b0, 1'b0, `FRAME_ROUND_WIDTH'(4), 1'b0);
    finish_frame(1'b0, 1'b0, 1'b0);

    // spurious start pulses while busy
    for (int f = 0; f < 3; f++) begin
      launch(1'b0, 1'($urandom_range(0, 1)), `FRAME_ROUND_WIDTH'($urandom), 1'b0);
      finish_frame(1'b0, 1'b0, 1'b1);
    end

    // random mix
    for (int f = 0; f < 6; f++) begin
      bit fl, rf, ex;
      fl = 1'($urandom_range(0, 3) == 0);
      rf = 1'($urandom_range(0, 1));
      ex = 1'($urandom_range(0, 1));
      launch(fl, 1'($urandom_range(0, 1)), `FRAME_ROUND_WIDTH'($urandom), 1'b0);
      finish_frame(fl, rf, ex);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
